// File: rtl/rst_sequencer_if.sv
// Reset-sequencer control bundle: software re-reset request in, staged
// active-low resets and completion flag out.
interface rst_sequencer_if #(
    parameter int unsigned NUM_OUT = 3
);
    logic               sw_rst_req;
    logic [NUM_OUT-1:0] rst_out_n;
    logic               rst_done;

    modport master (
        output sw_rst_req,
        input  rst_out_n,
        input  rst_done
    );

    modport slave (
        input  sw_rst_req,
        output rst_out_n,
        output rst_done
    );
endinterface

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: asynchronous assert, synchronized release, hold
// period, then per-domain release in bit order with software re-reset.
module rst_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned NUM_OUT     = 3,
    parameter int unsigned STAGGER     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    rst_sequencer_if.slave  bus
);
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IDX_W   = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

    localparam logic [1:0] ST_SYNC    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_OUT-1:0]     out_q, out_d;
    logic                   done_q, done_d;
    logic                   sync_q;

    assign sync_q        = sync_chain_q[SYNC_STAGES-1];
    assign bus.rst_out_n = out_q;
    assign bus.rst_done  = done_q;

    always_comb begin
        sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], 1'b1};
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        out_d        = out_q;
        done_d       = done_q;

        // Software request outranks every other transition except in SYNC.
        if (state_q != ST_SYNC && bus.sw_rst_req) begin
            out_d   = '0;
            done_d  = 1'b0;
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (sync_q) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        out_d[0] = 1'b1;
                        cnt_d    = '0;
                        idx_d    = IDX_W'(1);
                        if (NUM_OUT == 1) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STAG_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_q + 1'b1;
                        for (int unsigned i = 0; i < NUM_OUT; i++) begin
                            if (idx_q == IDX_W'(i)) out_d[i] = 1'b1;
                        end
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain_q <= '0;
            state_q      <= ST_SYNC;
            cnt_q        <= '0;
            idx_q        <= '0;
            out_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            sync_chain_q <= sync_chain_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            out_q        <= out_d;
            done_q       <= done_d;
        end
    end
endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: power-on, async abort, software re-reset,
// ignored request in SYNC, held request, and single-output corner.
module tb_rst_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    rst_sequencer_if #(.NUM_OUT(3)) bus ();
    rst_sequencer_if #(.NUM_OUT(1)) bus1 ();

    rst_sequencer #(
        .SYNC_STAGES(2), .HOLD_CYCLES(16), .NUM_OUT(3), .STAGGER(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    rst_sequencer #(
        .SYNC_STAGES(2), .HOLD_CYCLES(1), .NUM_OUT(1), .STAGGER(4)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // rel = edges since the edge that entered HOLD (defaults: 16 hold, 4 stagger)
    function automatic logic [2:0] exp_out(input int rel);
        logic [2:0] v = 3'b000;
        if (rel >= 16) v[0] = 1'b1;
        if (rel >= 20) v[1] = 1'b1;
        if (rel >= 24) v[2] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Run edges first_e..last_e after a power-on release, HOLD entered at edge 3.
    task automatic run_power_on(input string tag, input int first_e, input int last_e);
        for (int e = first_e; e <= last_e; e++) begin
            step();
            check({tag, "_out"}, 32'(bus.rst_out_n), 32'(exp_out(e - 3)));
            check({tag, "_done"}, 32'(bus.rst_done), 32'(e >= 27));
        end
    endtask

    task automatic run_after(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            step();
            check({tag, "_out"}, 32'(bus.rst_out_n), 32'(exp_out(k)));
            check({tag, "_done"}, 32'(bus.rst_done), 32'(k >= 24));
        end
    endtask

    initial begin
        bus.sw_rst_req  = 1'b0;
        bus1.sw_rst_req = 1'b0;

        // Power-on: reset held 3 cycles, released mid-cycle
        repeat (3) @(negedge clk);
        check("reset_out", 32'(bus.rst_out_n), 32'd0);
        check("reset_done", 32'(bus.rst_done), 32'd0);
        check("reset_out1", 32'(bus1.rst_out_n), 32'd0);
        rst_n = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            step();
            check("por_out", 32'(bus.rst_out_n), 32'(exp_out(e - 3)));
            check("por_done", 32'(bus.rst_done), 32'(e >= 27));
            check("corner_out", 32'(bus1.rst_out_n), 32'(e >= 4));
            check("corner_done", 32'(bus1.rst_done), 32'(e >= 4));
        end

        // Mid-sequence asynchronous reset between edges 21 and 22
        restart();
        run_power_on("pre_abort", 1, 21);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out", 32'(bus.rst_out_n), 32'd0);
        check("abort_done", 32'(bus.rst_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_power_on("post_abort", 1, 27);

        // Software re-reset in DONE
        step();
        step();
        bus.sw_rst_req = 1'b1;
        step();
        bus.sw_rst_req = 1'b0;
        check("sw_done_out", 32'(bus.rst_out_n), 32'd0);
        check("sw_done_done", 32'(bus.rst_done), 32'd0);
        run_after("sw_done", 24);

        // Request during SYNC (edges 1-2) must be ignored
        restart();
        bus.sw_rst_req = 1'b1;
        run_power_on("sync_req", 1, 2);
        bus.sw_rst_req = 1'b0;
        run_power_on("sync_req", 3, 27);

        // Held request across edges 21..30 during RELEASE
        restart();
        run_power_on("held_pre", 1, 20);
        bus.sw_rst_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("held_out", 32'(bus.rst_out_n), 32'd0);
            check("held_done", 32'(bus.rst_done), 32'd0);
        end
        bus.sw_rst_req = 1'b0;
        run_after("held_post", 24);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
